vga_mem_arbiter: RTL and testbench

- Shares one single-port 16-bit display/data memory between two requesters: the VGA bit generator (glyph, digit and pixel fetches) and the CPU load/store path.
- Sequences each memory access as an explicit issue/response transaction.
- Gives VGA priority during active video and CPU priority during blanking.
- Bounds CPU starvation with a wait counter.
- Sits between the CPU core, the bit generator and the block RAM.

---
 rtl/vga_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_vga_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Shares one synchronous single-port memory between the VGA bit generator and the CPU.
// VGA wins during active video, CPU wins in blanking, and a wait counter bounds CPU starvation.
module vga_mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CPU_WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bright,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        VGA_ISSUE,
        VGA_RESP,
        CPU_RD_ISSUE,
        CPU_RD_RESP,
        CPU_WR
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              mem_we_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              vga_ack_nxt;
    logic              cpu_ack_nxt;
    logic              cnt_at_max_c;
    logic              cpu_wins_c;
    logic              vga_wins_c;

    // Read data comes straight from the BRAM; the ack qualifies which requester owns it.
    assign vga_rdata = mem_rdata;
    assign cpu_rdata = mem_rdata;

    assign cnt_at_max_c = (wait_cnt == CNT_W'(CPU_WAIT_MAX));
    assign cpu_wins_c   = cpu_req && (!vga_req || !bright || cnt_at_max_c);
    assign vga_wins_c   = vga_req && !cpu_wins_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            vga_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_we    <= mem_we_nxt;
            mem_wdata <= mem_wdata_nxt;
            vga_ack   <= vga_ack_nxt;
            cpu_ack   <= cpu_ack_nxt;
        end
    end

    // Requests are only sampled in IDLE, so a req still high during RESP never re-issues.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        mem_addr_nxt  = mem_addr;
        mem_we_nxt    = 1'b0;
        mem_wdata_nxt = mem_wdata;

        case (state)
            IDLE: begin
                if (cpu_wins_c) begin
                    wait_cnt_nxt = '0;
                    mem_addr_nxt = cpu_addr;
                    if (cpu_we) begin
                        state_nxt     = CPU_WR;
                        mem_we_nxt    = 1'b1;
                        mem_wdata_nxt = cpu_wdata;
                    end else begin
                        state_nxt = CPU_RD_ISSUE;
                    end
                end else begin
                    if (vga_wins_c) begin
                        state_nxt    = VGA_ISSUE;
                        mem_addr_nxt = vga_addr;
                    end
                    if (!cpu_req) begin
                        wait_cnt_nxt = '0;
                    end else if (vga_wins_c && !cnt_at_max_c) begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
                end
            end
            VGA_ISSUE:    state_nxt = VGA_RESP;
            VGA_RESP:     state_nxt = IDLE;
            CPU_RD_ISSUE: state_nxt = CPU_RD_RESP;
            CPU_RD_RESP:  state_nxt = IDLE;
            CPU_WR:       state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase

        vga_ack_nxt = (state_nxt == VGA_RESP);
        cpu_ack_nxt = (state_nxt == CPU_RD_RESP) || (state_nxt == CPU_WR);
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a synchronous BRAM model and per-requester scoreboards.
module tb_vga_mem_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              bright;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic [DATA_W-1:0] vga_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    vga_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CPU_WAIT_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bright   (bright),
        .vga_req  (vga_req),
        .vga_addr (vga_addr),
        .vga_ack  (vga_ack),
        .vga_rdata(vga_rdata),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous read-first BRAM model
    logic [DATA_W-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic              is_wr;
        logic [DATA_W-1:0] data;
    } cpu_exp_t;

    logic [DATA_W-1:0] vga_q[$];
    cpu_exp_t          cpu_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack must match the oldest expectation of its requester
    always @(negedge clk) begin
        if (!reset) begin
            if (vga_ack) begin
                chk("vga_ack_expected", 32'(vga_q.size() != 0), 1);
                chk("ack_exclusive_v", 32'(cpu_ack), 0);
                if (vga_q.size() != 0) chk("vga_rdata", 32'(vga_rdata), 32'(vga_q.pop_front()));
            end
            if (cpu_ack) begin
                chk("cpu_ack_expected", 32'(cpu_q.size() != 0), 1);
                if (cpu_q.size() != 0) begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    if (e.is_wr) begin
                        chk("cpu_wr_we", 32'(mem_we), 1);
                        chk("cpu_wr_wdata", 32'(mem_wdata), 32'(e.data));
                    end else begin
                        chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                    end
                end
            end
        end
    end

    // Steps until both acks seen (dropping each req at its ack); -1 marks a timeout.
    task automatic run_pair(output int vt, output int ct);
        vt = -1;
        ct = -1;
        for (int t = 1; t <= 20 && (vt < 0 || ct < 0); t++) begin
            @(negedge clk);
            if (vga_ack && vt < 0) begin vt = t; vga_req = 1'b0; end
            if (cpu_ack && ct < 0) begin ct = t; cpu_req = 1'b0; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vt, ct, nv, nc, run;
        clk = 1'b0; reset = 1'b1; bright = 1'b0;
        vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem[16'h0102] = 16'hABCD;
        mem[16'h0103] = 16'h5A5A;
        mem[16'h0200] = 16'h1111;
        mem[16'h0300] = 16'h2222;

        repeat (2) @(negedge clk);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_vga_ack", 32'(vga_ack), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        reset = 1'b0;
        @(negedge clk);

        // VGA-only read, then a back-to-back request held across the ack
        vga_addr = 16'h0102; vga_req = 1'b1; vga_q.push_back(16'hABCD);
        @(negedge clk);
        chk("t1_c1_addr", 32'(mem_addr), 32'h0102);
        chk("t1_c1_we", 32'(mem_we), 0);
        chk("t1_c1_ack", 32'(vga_ack), 0);
        @(negedge clk);
        chk("t1_c2_ack", 32'(vga_ack), 1);
        chk("t1_c2_we", 32'(mem_we), 0);
        vga_addr = 16'h0103; vga_q.push_back(16'h5A5A);
        @(negedge clk);
        chk("t1_c3_ack", 32'(vga_ack), 0);
        chk("t1_c3_addr", 32'(mem_addr), 32'h0102);
        @(negedge clk);
        chk("t1_c4_addr", 32'(mem_addr), 32'h0103);
        @(negedge clk);
        chk("t1_c5_ack", 32'(vga_ack), 1);
        vga_req = 1'b0;
        @(negedge clk);

        // CPU write then readback in blanking
        cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234; cpu_req = 1'b1;
        cpu_q.push_back(cpu_exp_t'({1'b1, 16'h1234}));
        @(negedge clk);
        chk("t2_wr_we", 32'(mem_we), 1);
        chk("t2_wr_ack", 32'(cpu_ack), 1);
        chk("t2_wr_addr", 32'(mem_addr), 32'h0040);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("t2_wr_we_off", 32'(mem_we), 0);
        chk("t2_wr_ack_off", 32'(cpu_ack), 0);
        cpu_we = 1'b0; cpu_req = 1'b1;
        cpu_q.push_back(cpu_exp_t'({1'b0, 16'h1234}));
        @(negedge clk);
        chk("t2_rd_c1_ack", 32'(cpu_ack), 0);
        chk("t2_rd_c1_addr", 32'(mem_addr), 32'h0040);
        chk("t2_rd_c1_we", 32'(mem_we), 0);
        @(negedge clk);
        chk("t2_rd_c2_ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests in active video: VGA first
        bright = 1'b1;
        vga_addr = 16'h0200; cpu_addr = 16'h0300; cpu_we = 1'b0;
        vga_req = 1'b1; cpu_req = 1'b1;
        vga_q.push_back(16'h1111); cpu_q.push_back(cpu_exp_t'({1'b0, 16'h2222}));
        run_pair(vt, ct);
        chk("t3_vga_lat", 32'(vt), 2);
        chk("t3_cpu_lat", 32'(ct), 5);
        @(negedge clk);

        // Simultaneous requests in blanking: CPU first
        bright = 1'b0;
        vga_req = 1'b1; cpu_req = 1'b1;
        vga_q.push_back(16'h1111); cpu_q.push_back(cpu_exp_t'({1'b0, 16'h2222}));
        run_pair(vt, ct);
        chk("t4_vga_lat", 32'(vt), 5);
        chk("t4_cpu_lat", 32'(ct), 2);
        @(negedge clk);

        // Starvation bound: 4 VGA grants per forced CPU grant, three rounds
        bright = 1'b1;
        for (int i = 0; i < 12; i++) vga_q.push_back(16'h1111);
        for (int i = 0; i < 3; i++) cpu_q.push_back(cpu_exp_t'({1'b0, 16'h2222}));
        vga_req = 1'b1; cpu_req = 1'b1;
        nv = 0; nc = 0; run = 0;
        for (int t = 0; t < 100 && nc < 3; t++) begin
            @(negedge clk);
            if (vga_ack) begin nv++; run++; end
            if (cpu_ack) begin
                nc++;
                chk($sformatf("t5_run%0d", nc), 32'(run), 4);
                run = 0;
                if (nc == 3) begin vga_req = 1'b0; cpu_req = 1'b0; end
            end
        end
        chk("t5_vga_total", 32'(nv), 12);
        chk("t5_cpu_total", 32'(nc), 3);
        @(negedge clk);

        // Reset during VGA_ISSUE abandons the read and clears the wait counter
        vga_addr = 16'h0102; cpu_addr = 16'h0300; cpu_we = 1'b0;
        vga_req = 1'b1; cpu_req = 1'b1;
        @(negedge clk);
        chk("t6_c1_addr", 32'(mem_addr), 32'h0102);
        chk("t6_c1_cnt", 32'(dut.wait_cnt), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_vga_ack", 32'(vga_ack), 0);
        chk("t6_rst_cpu_ack", 32'(cpu_ack), 0);
        chk("t6_rst_we", 32'(mem_we), 0);
        chk("t6_rst_addr", 32'(mem_addr), 0);
        chk("t6_rst_cnt", 32'(dut.wait_cnt), 0);
        reset = 1'b0;
        vga_q.push_back(16'hABCD); cpu_q.push_back(cpu_exp_t'({1'b0, 16'h2222}));
        run_pair(vt, ct);
        chk("t6_vga_lat", 32'(vt), 2);
        chk("t6_cpu_lat", 32'(ct), 5);
        @(negedge clk);

        chk("vga_q_drained", 32'(vga_q.size()), 0);
        chk("cpu_q_drained", 32'(cpu_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
